// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// frame geometry and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;
  // 143 clocks x 14 ns ~= 2000 ns, the host bit period.
  localparam int CLKS_PER_BIT   = 143;

endpackage

// File: rtl/uart_tx_if.sv
// Byte push handshake between the core's store path and the transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] DIN;
  logic                      DIN_VALID;
  logic                      DIN_READY;

  modport master (output DIN, output DIN_VALID, input  DIN_READY);
  modport slave  (input  DIN, input  DIN_VALID, output DIN_READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock byte FIFO, depth 2**FIFO_AW, no bypass:
// a pushed byte becomes visible at the head on the following cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] din,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic [FIFO_AW:0]          count,
  output logic                      full,
  output logic                      empty
);

  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

  logic [UART_DATA_BITS-1:0] mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0]        wptr_q, wptr_d;
  logic [FIFO_AW-1:0]        rptr_q, rptr_d;
  logic [FIFO_AW:0]          count_q, count_d;
  logic                      do_push, do_pop;

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at the depth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared by reset so a reset drops every queued byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent LSB-first as start, 8 data,
// optional even parity, stop. Define UART_TX_PARITY_EN for 11-bit frames
// with even parity; otherwise frames are plain 8N1.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int FIFO_AW      = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_if.slave       tx_if,
  output logic           RS_TX,
  output logic           BUSY,
  output logic [FIFO_AW:0] FIFO_COUNT
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  uart_state_e               state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic                      pop, push, full, empty, baud_end;
  logic [UART_DATA_BITS-1:0] fifo_dout;

  assign push            = tx_if.DIN_VALID && tx_if.DIN_READY;
  assign tx_if.DIN_READY = !full && !RST;
  assign baud_end        = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign RS_TX           = tx_q;
  assign BUSY            = (state_q != ST_IDLE) || !empty;

  uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   (tx_if.DIN),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (FIFO_COUNT),
    .full  (full),
    .empty (empty)
  );

  // Next-state logic; tx_d is the line level for the coming cycle so the
  // pin is driven straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + BAUD_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_dout;
`endif
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          // Chain straight into the next frame when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FSM, baud counter, bit index, shift register and line flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset/idle, single frame, back-to-back
// frames, FIFO overflow, reset mid-frame and parity-sensitive bytes.
module tb_uart_tx;

  localparam int C = 143;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       RS_TX;
  logic       BUSY;
  logic [4:0] FIFO_COUNT;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_if tx_if ();

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tx_if      (tx_if),
    .RS_TX      (RS_TX),
    .BUSY       (BUSY),
    .FIFO_COUNT (FIFO_COUNT)
  );

  always #7 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every cycle of a frame against the expected line levels.
  // Entered at the negedge of start-bit cycle pre (0-based).
  task automatic check_frame(input logic [7:0] b, input int pre, input bit hold_full,
                             input string tag);
    logic [10:0] lvl;
    int          fbad;
    lvl = '1;
    lvl[0] = 1'b0;
    for (int i = 0; i < 8; i++) lvl[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    lvl[9] = ^b;
`endif
    fbad = 0;
    for (int s = 0; s < NB; s++) begin
      int bad;
      bad = 0;
      for (int c = (s == 0) ? pre : 0; c < C; c++) begin
        if (RS_TX !== lvl[s]) bad++;
        if (hold_full && (FIFO_COUNT !== 5'd16 || tx_if.DIN_READY !== 1'b0)) fbad++;
        @(negedge CLK);
      end
      chk($sformatf("%s slot%0d badcycles", tag, s), bad, 0);
    end
    if (hold_full) chk({tag, " full-hold badcycles"}, fbad, 0);
  endtask

  // One byte into an idle transmitter, frame checked, then back to idle.
  task automatic single(input logic [7:0] b, input string tag);
    tx_if.DIN = b;
    tx_if.DIN_VALID = 1'b1;
    @(negedge CLK);
    tx_if.DIN_VALID = 1'b0;
    chk({tag, " count after accept"}, FIFO_COUNT, 1);
    chk({tag, " line high after accept"}, RS_TX, 1);
    @(negedge CLK);
    chk({tag, " busy in frame"}, BUSY, 1);
    check_frame(b, 0, 1'b0, tag);
    chk({tag, " line idle after"}, RS_TX, 1);
    chk({tag, " busy clear after"}, BUSY, 0);
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] ov  [20];
    int acc, bad;

    RST = 1'b1;
    tx_if.DIN = 8'h00;
    tx_if.DIN_VALID = 1'b0;

    // Reset then idle.
    repeat (3) @(negedge CLK);
    chk("ready low in reset", tx_if.DIN_READY, 0);
    chk("reset line", RS_TX, 1);
    chk("reset busy", BUSY, 0);
    chk("reset count", FIFO_COUNT, 0);
    RST = 1'b0;
    #1;
    chk("ready after reset", tx_if.DIN_READY, 1);
    bad = 0;
    repeat (500) begin
      @(negedge CLK);
      if (RS_TX !== 1'b1 || BUSY !== 1'b0 || FIFO_COUNT !== 5'd0) bad++;
    end
    chk("idle 500 badcycles", bad, 0);

    // Single byte 0x0A.
    single(8'h0A, "b0A");

    // Back-to-back 00,00,00,0A pushed on consecutive edges.
    seq[0] = 8'h00; seq[1] = 8'h00; seq[2] = 8'h00; seq[3] = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      tx_if.DIN = seq[i];
      tx_if.DIN_VALID = 1'b1;
      @(negedge CLK);
    end
    tx_if.DIN_VALID = 1'b0;
    chk("b2b count", FIFO_COUNT, 3);
    check_frame(seq[0], 2, 1'b0, "b2b f0");
    for (int i = 1; i < 4; i++) check_frame(seq[i], 0, 1'b0, $sformatf("b2b f%0d", i));
    chk("b2b line idle", RS_TX, 1);
    chk("b2b busy clear", BUSY, 0);

    // Overflow: 20 cycles of DIN_VALID, 17 accepted.
    for (int i = 0; i < 20; i++) ov[i] = 8'h40 + 8'(i * 7);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      tx_if.DIN = ov[acc];
      tx_if.DIN_VALID = 1'b1;
      if (tx_if.DIN_READY === 1'b1) acc++;
      @(negedge CLK);
    end
    tx_if.DIN_VALID = 1'b0;
    chk("ovf accepted", acc, 17);
    chk("ovf count", FIFO_COUNT, 16);
    chk("ovf ready", tx_if.DIN_READY, 0);
    check_frame(ov[0], 18, 1'b1, "ovf f0");
    chk("ovf ready after pop", tx_if.DIN_READY, 1);
    chk("ovf count after pop", FIFO_COUNT, 15);
    for (int i = 1; i < 17; i++) check_frame(ov[i], 0, 1'b0, $sformatf("ovf f%0d", i));
    chk("ovf busy clear", BUSY, 0);
    chk("ovf count end", FIFO_COUNT, 0);

    // Reset during data bit 3 of 0xFF with 5 bytes queued.
    for (int i = 0; i < 6; i++) begin
      tx_if.DIN = (i == 0) ? 8'hFF : 8'h10 + 8'(i);
      tx_if.DIN_VALID = 1'b1;
      @(negedge CLK);
    end
    tx_if.DIN_VALID = 1'b0;
    repeat (4 * C - 4 + C / 2) @(negedge CLK);
    chk("mid bit3 line", RS_TX, 1);
    chk("mid bit3 count", FIFO_COUNT, 5);
    chk("mid bit3 busy", BUSY, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst mid line", RS_TX, 1);
    chk("rst mid count", FIFO_COUNT, 0);
    chk("rst mid busy", BUSY, 0);
    chk("rst mid ready", tx_if.DIN_READY, 0);
    RST = 1'b0;
    bad = 0;
    repeat (2 * NB * C) begin
      @(negedge CLK);
      if (RS_TX !== 1'b1 || BUSY !== 1'b0 || FIFO_COUNT !== 5'd0) bad++;
    end
    chk("post reset quiet badcycles", bad, 0);

    // Parity-sensitive bytes (odd and even weight).
    single(8'h07, "b07");
    single(8'h03, "b03");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
